// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target controller.
package i2c_slave_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK
    } i2c_slave_state_t;

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// Pin and byte-stream bundle of the I2C target controller.
// slave modport: the controller; master modport: the environment driving it.
interface i2c_slave_ctrl_if;
    import i2c_slave_pkg::*;

    logic                  scl_i;
    logic                  sda_i;
    logic                  sda_oe;
    logic                  scl_oe;
    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_req;
    logic                  tx_valid;
    logic [I2C_BYTE_W-1:0] tx_data;
    logic                  busy;
    logic                  start_det;
    logic                  stop_det;

    modport slave (
        input  scl_i, sda_i, tx_valid, tx_data,
        output sda_oe, scl_oe, rx_data, rx_valid, tx_req, busy, start_det, stop_det
    );

    modport master (
        output scl_i, sda_i, tx_valid, tx_data,
        input  sda_oe, scl_oe, rx_data, rx_valid, tx_req, busy, start_det, stop_det
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for an asynchronous bus pin plus rise/fall detection
// on the synchronized level.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain and previous-level flop; reset to the idle-high bus level
    // so that leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target controller: START/STOP detection, 7-bit address match, write bytes
// delivered on rx_*, read bytes fetched through tx_req/tx_valid.
// Define I2C_SLAVE_CLK_STRETCH_EN to stretch SCL on a read underrun instead of
// sending 8'hFF.
module i2c_slave_ctrl
    import i2c_slave_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    i2c_slave_ctrl_if.slave bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_cond, stop_cond;
    logic load_byte;

    i2c_slave_state_t      state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic                  rw_q, rw_d;
    logic [6:0]            tx_shift_q, tx_shift_d;  // bits still to send after bit 7
    logic [I2C_BYTE_W-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_full_q, tx_full_d;    // tx_buf holds an unsent byte
    logic                  sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_req_q, tx_req_d;
    logic                  busy_q, busy_d;
    logic                  start_det_q, start_det_d;
    logic                  stop_det_q, stop_det_d;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    logic                  scl_oe_q, scl_oe_d;
    logic                  stretch_q, stretch_d;
    logic [7:0]            rel_cnt_q, rel_cnt_d;
`endif

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_cond = scl_lvl & sda_fall;
    assign stop_cond  = scl_lvl & sda_rise;

    // Next-state and output decode; bus conditions override everything at the end.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = tx_req_q;
        busy_d      = busy_q;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        load_byte   = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        scl_oe_d    = scl_oe_q;
        stretch_d   = stretch_q;
        rel_cnt_d   = rel_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
            end
            ADDR: begin
                if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_lvl};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        if (shift_d[7:1] == SLAVE_ADDR) begin
                            state_d = ADDR_ACK;
                            rw_d    = sda_lvl;
                            busy_d  = 1'b1;
                            if (sda_lvl) tx_req_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            ADDR_ACK: begin
                // First fall starts the ACK, second fall ends it.
                if (scl_fall) begin
                    if (cnt_q == 4'd0) begin
                        sda_oe_d = 1'b1;
                        cnt_d    = 4'd1;
                    end else if (rw_q) begin
                        state_d   = RD;
                        load_byte = 1'b1;
                    end else begin
                        state_d  = WR;
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                    end
                end
            end
            WR: begin
                if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_lvl};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                        state_d    = WR_ACK;
                        cnt_d      = 4'd0;
                    end
                end
            end
            WR_ACK: begin
                if (scl_fall) begin
                    if (cnt_q == 4'd0) begin
                        sda_oe_d = 1'b1;
                        cnt_d    = 4'd1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = WR;
                        cnt_d    = 4'd0;
                    end
                end
            end
            RD: begin
                // cnt counts bits already placed on SDA.
                if (scl_fall) begin
                    if (cnt_q == 4'd0) begin
                        load_byte = 1'b1;
                    end else if (cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = RD_ACK;
                        cnt_d    = 4'd0;
                    end else begin
                        sda_oe_d   = ~tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[5:0], 1'b1};
                        cnt_d      = cnt_q + 4'd1;
                    end
                end
            end
            RD_ACK: begin
                if (scl_rise) begin
                    if (!sda_lvl) begin
                        state_d = RD;
                        if (!tx_full_q) tx_req_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        tx_req_d  = 1'b0;
                        tx_full_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Present bit 7 of the next read byte, or handle an underrun.
        if (load_byte) begin
            cnt_d = 4'd1;
            if (tx_full_q) begin
                sda_oe_d   = ~tx_buf_q[7];
                tx_shift_d = tx_buf_q[6:0];
                tx_full_d  = 1'b0;
            end else begin
                sda_oe_d = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                stretch_d = 1'b1;
                scl_oe_d  = 1'b1;
`else
                tx_shift_d = 7'h7F;
`endif
            end
        end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
        // Late byte arrived while SCL is held: drive bit 7, release SCL after a hold.
        if (stretch_q && tx_full_q) begin
            sda_oe_d   = ~tx_buf_q[7];
            tx_shift_d = tx_buf_q[6:0];
            tx_full_d  = 1'b0;
            stretch_d  = 1'b0;
            rel_cnt_d  = 8'(SYNC_STAGES + 1);
        end else if (rel_cnt_q != 8'd0) begin
            rel_cnt_d = rel_cnt_q - 8'd1;
            if (rel_cnt_q == 8'd1) scl_oe_d = 1'b0;
        end
`endif

        // Accept a read byte; tx_req drops the following cycle.
        if (tx_req_q && bus.tx_valid) begin
            tx_buf_d  = bus.tx_data;
            tx_full_d = 1'b1;
            tx_req_d  = 1'b0;
        end

        if (start_cond || stop_cond) begin
            state_d     = start_cond ? ADDR : IDLE;
            start_det_d = start_cond;
            stop_det_d  = stop_cond;
            cnt_d       = 4'd0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            tx_req_d    = 1'b0;
            tx_full_d   = 1'b0;
            rx_valid_d  = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oe_d    = 1'b0;
            stretch_d   = 1'b0;
            rel_cnt_d   = 8'd0;
`endif
        end
    end

    // State and output registers; reset releases both lines immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            tx_shift_q  <= '1;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            busy_q      <= busy_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
        end
    end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    // Clock-stretch control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_oe_q  <= 1'b0;
            stretch_q <= 1'b0;
            rel_cnt_q <= 8'd0;
        end else begin
            scl_oe_q  <= scl_oe_d;
            stretch_q <= stretch_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end
    assign bus.scl_oe = scl_oe_q;
`else
    assign bus.scl_oe = 1'b0;
`endif

    assign bus.sda_oe    = sda_oe_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_req    = tx_req_q;
    assign bus.busy      = busy_q;
    assign bus.start_det = start_det_q;
    assign bus.stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bus-master tasks on an open-drain model, a tx_data
// responder, and a monitor that checks DUT outputs against queued expectations.
module tb_i2c_slave_ctrl;
    import i2c_slave_pkg::*;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic rst;
    logic m_scl_low, m_sda_low;

    i2c_slave_ctrl_if bus ();

    assign bus.scl_i = ~(m_scl_low | bus.scl_oe);
    assign bus.sda_i = ~(m_sda_low | bus.sda_oe);

    i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rd_obs[$];
    logic [7:0] tx_src[$];
    logic [7:0] wbuf[$];
    int n_rx = 0, n_start = 0, n_stop = 0, n_txreq = 0;
    int exp_starts = 0, exp_stops = 0;
    int sda_oe_cycles = 0, scl_oe_cycles = 0;
    bit big_delay = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops expectations whenever the DUT or the bus master presents data.
    initial begin
        logic rx_prev, req_prev;
        rx_prev = 1'b0;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rx_valid) begin
                    n_rx++;
                    chk("rx_valid_width", 32'(rx_prev), 0);
                    if (exp_rx.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_unexpected: got %0h, expected no byte", bus.rx_data);
                    end else begin
                        chk("rx_data", bus.rx_data, exp_rx.pop_front());
                    end
                end
                while (rd_obs.size() > 0) begin
                    if (exp_rd.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rd_unexpected: got %0h, expected no byte", rd_obs[0]);
                        void'(rd_obs.pop_front());
                    end else begin
                        chk("rd_byte", rd_obs.pop_front(), exp_rd.pop_front());
                    end
                end
                if (bus.start_det) n_start++;
                if (bus.stop_det) n_stop++;
                if (bus.tx_req && !req_prev) n_txreq++;
                if (bus.sda_oe) sda_oe_cycles++;
                if (bus.scl_oe) scl_oe_cycles++;
                rx_prev = bus.rx_valid;
                req_prev = bus.tx_req;
            end
        end
    end

    // tx_data responder: answers each tx_req after a short random (or one long) delay.
    initial begin
        int wait_cnt, cur_delay;
        bit active;
        active = 1'b0;
        wait_cnt = 0;
        cur_delay = 0;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.tx_valid) begin
                bus.tx_valid = 1'b0;
            end else if (bus.tx_req && !rst) begin
                if (!active) begin
                    active = 1'b1;
                    wait_cnt = 0;
                    cur_delay = big_delay ? 200 : int'($urandom_range(0, 6));
                    big_delay = 1'b0;
                end
                if (wait_cnt >= cur_delay) begin
                    bus.tx_data = (tx_src.size() > 0) ? tx_src.pop_front() : 8'h00;
                    bus.tx_valid = 1'b1;
                    active = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    task automatic q_wait();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic scl_high();
        m_scl_low = 1'b0;
        for (int i = 0; i < 3000 && bus.scl_i == 1'b0; i++) @(posedge clk);
        #1;
        if (bus.scl_i == 1'b0) chk("scl_release_timeout", 32'(bus.scl_i), 1);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        m_sda_low = ~b;
        q_wait();
        scl_high();
        q_wait();
        r = bus.sda_i;
        q_wait();
        m_scl_low = 1'b1;
        q_wait();
    endtask

    task automatic m_start();
        m_sda_low = 1'b0;
        q_wait();
        scl_high();
        q_wait();
        m_sda_low = 1'b1;
        q_wait();
        m_scl_low = 1'b1;
        q_wait();
        exp_starts++;
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1;
        q_wait();
        scl_high();
        q_wait();
        m_sda_low = 1'b0;
        q_wait();
        q_wait();
        exp_stops++;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_n);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, ack_n);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, d[i]);
        bus_bit(nack, r);
    endtask

    // Write transaction: address ACK only for the target address, then every data
    // byte is ACKed and delivered on rx_data in order.
    task automatic wr_txn(input logic [6:0] a, input bit do_start, input bit do_stop);
        logic ack_n;
        bit match;
        match = (a == 7'h50);
        if (do_start) m_start();
        write_byte({a, 1'b0}, ack_n);
        chk("addr_ack_w", 32'(ack_n), 32'(!match));
        chk("busy_after_addr", 32'(bus.busy), 32'(match));
        if (match) begin
            foreach (wbuf[i]) begin
                exp_rx.push_back(wbuf[i]);
                write_byte(wbuf[i], ack_n);
                chk("data_ack", 32'(ack_n), 0);
            end
        end
        if (do_stop) m_stop();
    endtask

    // Read transaction of n bytes, master ACKs all but the last.
    task automatic rd_txn(input logic [6:0] a, input int n, input bit auto_data);
        logic ack_n;
        logic [7:0] d, b;
        bit match;
        match = (a == 7'h50);
        if (match && auto_data) begin
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                tx_src.push_back(b);
                exp_rd.push_back(b);
            end
        end
        m_start();
        write_byte({a, 1'b1}, ack_n);
        chk("addr_ack_r", 32'(ack_n), 32'(!match));
        if (match) begin
            for (int i = 0; i < n; i++) begin
                read_byte(i == n - 1, d);
                rd_obs.push_back(d);
            end
        end
        m_stop();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0, s0, tr0;
        logic r;
        logic [6:0] ra;
        m_scl_low = 1'b0;
        m_sda_low = 1'b0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_sda_oe", 32'(bus.sda_oe), 0);
        chk("rst_scl_oe", 32'(bus.scl_oe), 0);
        chk("rst_rx_data", 32'(bus.rx_data), 0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 0);
        chk("rst_tx_req", 32'(bus.tx_req), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_start_det", 32'(bus.start_det), 0);
        chk("rst_stop_det", 32'(bus.stop_det), 0);
        q_wait();

        // Directed write of two bytes.
        rx0 = n_rx;
        wbuf = '{8'h3C, 8'hC3};
        wr_txn(7'h50, 1'b1, 1'b1);
        chk("wr_rx_count", n_rx - rx0, 2);
        chk("wr_rx_data_held", 32'(bus.rx_data), 32'hC3);
        chk("wr_busy_after_stop", 32'(bus.busy), 0);
        chk("wr_stop_count", n_stop, exp_stops);

        // Wrong address: never driven, never busy.
        rx0 = n_rx;
        sda_oe_cycles = 0;
        wbuf = '{8'h77};
        wr_txn(7'h51, 1'b1, 1'b1);
        chk("nomatch_sda_oe_cycles", sda_oe_cycles, 0);
        chk("nomatch_busy", 32'(bus.busy), 0);
        chk("nomatch_rx_count", n_rx - rx0, 0);

        // Directed read: A5 then 5A, ACK then NACK.
        tr0 = n_txreq;
        tx_src.push_back(8'hA5);
        tx_src.push_back(8'h5A);
        exp_rd.push_back(8'hA5);
        exp_rd.push_back(8'h5A);
        rd_txn(7'h50, 2, 1'b0);
        chk("rd_txreq_count", n_txreq - tr0, 2);
        chk("rd_sda_released", 32'(bus.sda_oe), 0);

        // Write then repeated START into a read.
        s0 = n_start;
        wbuf = '{8'h11};
        wr_txn(7'h50, 1'b1, 1'b0);
        rd_txn(7'h50, 1, 1'b1);
        chk("rs_start_count", n_start - s0, 2);
        chk("rs_rx_data", 32'(bus.rx_data), 32'h11);

        // STOP in the middle of a data byte.
        rx0 = n_rx;
        wbuf.delete();
        wr_txn(7'h50, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), r);
        m_stop();
        chk("midstop_rx_count", n_rx - rx0, 0);
        chk("midstop_busy", 32'(bus.busy), 0);

        // Read underrun: first tx_valid arrives 200 clk late.
        scl_oe_cycles = 0;
        big_delay = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        tx_src.push_back(8'h96);
        tx_src.push_back(8'h3E);
        exp_rd.push_back(8'h96);
        exp_rd.push_back(8'h3E);
        rd_txn(7'h50, 2, 1'b0);
        chk("stretch_scl_held", 32'(scl_oe_cycles >= 100), 1);
`else
        tx_src.push_back(8'h96);
        exp_rd.push_back(8'hFF);
        exp_rd.push_back(8'h96);
        rd_txn(7'h50, 2, 1'b0);
        chk("nostretch_scl_oe_cycles", scl_oe_cycles, 0);
`endif

        // Reset while the address ACK is being driven.
        m_start();
        for (int i = 7; i >= 1; i--) bus_bit(7'h50 >> (i - 1), r);
        bus_bit(1'b0, r);
        m_sda_low = 1'b0;
        for (int i = 0; i < 50 && !bus.sda_oe; i++) @(negedge clk);
        chk("ack_driven_before_rst", 32'(bus.sda_oe), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_sda_oe", 32'(bus.sda_oe), 0);
        chk("rst_async_scl_oe", 32'(bus.scl_oe), 0);
        chk("rst_async_busy", 32'(bus.busy), 0);
        chk("rst_async_rx_data", 32'(bus.rx_data), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_scl_low = 1'b0;
        q_wait();
        q_wait();
        wbuf = '{8'($urandom)};
        wr_txn(7'h50, 1'b1, 1'b1);

        // Randomized transactions against the reference rules.
        for (int t = 0; t < 8; t++) begin
            ra = ($urandom_range(0, 3) != 0) ? 7'h50 : 7'($urandom);
            if (ra == 7'h50 && $urandom_range(0, 3) == 0) ra = 7'h2A;
            if ($urandom_range(0, 1) == 0) begin
                wbuf.delete();
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) wbuf.push_back(8'($urandom));
                wr_txn(ra, 1'b1, 1'b1);
            end else begin
                rd_txn(ra, int'($urandom_range(1, 3)), 1'b1);
            end
        end

        repeat (20) @(negedge clk);
        chk("end_exp_rx_empty", exp_rx.size(), 0);
        chk("end_exp_rd_empty", exp_rd.size(), 0);
        chk("end_tx_src_empty", tx_src.size(), 0);
        chk("end_start_count", n_start, exp_starts);
        chk("end_stop_count", n_stop, exp_stops);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave_ctrl.md
# i2c_slave_ctrl

I2C target (slave) controller: the responder counterpart of the I2C master controller that drives the shared open-drain `scl`/`sda` bus in the i2c example designs. It detects START/STOP, matches a 7-bit address, ACKs and delivers written bytes, and serializes read bytes from a simple request/valid byte interface. It serves both as a synthesizable target and as the bus-side peer in the i2c testbenches.

## Interface
- `SLAVE_ADDR`, 7'h50: 7-bit target address.
- `SYNC_STAGES`, 2: synchronizer depth on SCL/SDA inputs (≥2).
- `clk` in 1: system clock; must run ≥ 8× SCL.
- `rst` in 1: reset; one clock, asynchronous, active-high.
- `scl_i` in 1: SCL pin level.
- `sda_i` in 1: SDA pin level.
- `sda_oe` out 1: 1 = drive SDA low; 0 = release.
- `scl_oe` out 1: 1 = drive SCL low (stretch); tied 0 without `I2C_SLAVE_CLK_STRETCH_EN`.
- `rx_data` out 8: last written byte; held until the next `rx_valid`.
- `rx_valid` out 1: one-cycle pulse per received data byte.
- `tx_req` out 1: level; a read byte is needed.
- `tx_valid` in 1: `tx_data` valid; consumed when `tx_req && tx_valid`.
- `tx_data` in 8: read byte, MSB first.
- `busy` out 1: high from address match until STOP, repeated START or NACK.
- `start_det`, `stop_det` out 1: one-cycle pulses on bus START/STOP.

## Operation
- Inputs pass through `SYNC_STAGES` flops. Edge detection uses synchronized values only.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are honoured in every state.
  - START, including repeated START: go to ADDR, clear the bit counter, release SDA.
  - STOP: go to IDLE, release all lines.
- Data is sampled on SCL rising edges. `sda_oe` changes only on SCL falling edges.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (addr[6:0], R/W).
    - On a match, go to ADDR_ACK.
    - On a mismatch, go to IDLE and keep SDA released.
  - ADDR_ACK: drive ACK. At the ACK-ending SCL fall, go to WR (R/W=0) or RD (R/W=1).
  - WR: shift 8 bits. On the 8th rise, update `rx_data` and pulse `rx_valid`; go to WR_ACK.
  - WR_ACK: drive ACK (always); return to WR.
  - RD: drive bits 7..0 of the latched byte; go to RD_ACK.
  - RD_ACK: release SDA and sample the master bit on the 9th rise.
    - 0 (ACK): raise `tx_req`; return to RD.
    - 1 (NACK): clear `busy`; go to IDLE and wait for STOP/START.
- `tx_req` timing:
  - Rises on entry to ADDR_ACK (read) or on a master ACK in RD_ACK.
  - Falls the cycle after `tx_valid` is seen; the byte is latched in that same cycle.
- Underrun: `tx_req` still high at the SCL fall that must present bit 7.
  - Without stretch: send 8'hFF (SDA released). `tx_req` stays high until satisfied or IDLE; a late `tx_data` is used for the next byte.

## Timing
- Reset values: `sda_oe`=0, `scl_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_req`=0, `busy`=0, `start_det`=0, `stop_det`=0. State is IDLE.
- Reset mid-transfer releases both lines immediately (asynchronously).
- Pin-to-detect latency: `SYNC_STAGES`+1 clk.
- `rx_valid` pulses 1 clk after the 8th data SCL rise is detected.
- `sda_oe` updates 1 clk after an SCL fall is detected. This gives hold ≥ (`SYNC_STAGES`+2) clk.
- ACK drive:
  - Asserted after the 8th SCL fall of a byte.
  - Released after the 9th SCL fall (write), or replaced by bit 7 of the next byte (read).
- `start_det`/`stop_det` pulse 1 clk after detection.
- START/STOP take precedence over a same-cycle SCL edge.

## Configuration
- `I2C_SLAVE_CLK_STRETCH_EN` defined:
  - On an underrun, hold `scl_oe`=1 from that SCL fall until `tx_valid` arrives.
  - Then drive bit 7, and release SCL ≥`SYNC_STAGES`+1 clk later.
  - START/STOP or reset release SCL immediately.
- Undefined: `scl_oe` is constant 0, and an underrun sends 8'hFF.

## Structure
- `i2c_slave_pkg`:
  - `i2c_slave_state_t` enum: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK.
  - Constants `I2C_ADDR_W`=7, `I2C_BYTE_W`=8.
- Sub-module `i2c_sync_edge`: synchronizer plus rise/fall detector, instantiated for SCL and SDA.

## Test plan
- Write 0xA0 (0x50, W), data 0x3C, 0xC3, STOP -> ACK on all three bytes, `rx_data` 0x3C then 0xC3, two single-cycle `rx_valid` pulses, `stop_det` pulse, `busy`=0.
- Address 0xA2 (0x51) -> `sda_oe` never asserted, `busy`=0, no `rx_valid`.
- Read 0xA1, `tx_data` 0xA5 then 0x5A, master ACK then NACK -> SDA shows 1010_0101 and 0101_1010, `tx_req` raised twice, SDA released after NACK.
- Write 0xA0 + 0x11, repeated START, read 0xA1 -> `start_det` twice, `rx_data`=0x11, read proceeds; STOP mid-byte -> IDLE, no `rx_valid`.
- Read with `tx_valid` delayed 200 clk -> with macro: `scl_oe`=1 for the delay, then correct byte; without: byte 0xFF, `scl_oe`=0.
- Assert `rst` mid-ACK -> `sda_oe`/`scl_oe` drop in the same cycle, all outputs at reset values, next START accepted.
